// File: rtl/instruction_fetcher_pkg.sv
// Shared types, widths and constants for the instruction fetch stage.
// Imported by the fetcher and by anything that needs its state encoding.
package instruction_fetcher_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int INST_WIDTH = 32;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [INST_WIDTH-1:0] inst_t;

    localparam addr_t DEFAULT_RESET_PC = 32'h0000_0000;
    localparam addr_t PC_STEP          = 32'd4;

    typedef enum logic [1:0] {
        LOOKUP  = 2'd0,
        MISS    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetcher.sv
// Front-end fetch stage: owns the PC, probes the I-cache, services misses from
// the memory controller and hands {inst, pc} to the decoder through a one-entry slot.
module instruction_fetcher
    import instruction_fetcher_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,

    output logic [31:0] if_to_ic_inst_addr,
    input  logic        ic_to_if_hit,
    input  logic [31:0] ic_to_if_hit_inst,
    output logic [31:0] if_to_ic_inst,
    output logic        if_to_ic_inst_valid,

    output logic        if_to_mc_req,
    output logic [31:0] if_to_mc_addr,
    input  logic        mc_to_if_done,
    input  logic [31:0] mc_to_if_inst,

    output logic        if_to_dec_valid,
    output logic [31:0] if_to_dec_inst,
    output logic [31:0] if_to_dec_pc,
    input  logic        dec_to_if_ready,

    input  logic        rob_to_if_jump,
    input  logic [31:0] rob_to_if_jump_addr
);

    fetch_state_e state, state_nxt;
    addr_t        pc, pc_nxt;
    addr_t        miss_addr, miss_addr_nxt;
    addr_t        mc_addr_nxt, dec_pc_nxt;
    inst_t        dec_inst_nxt;
    logic         req_nxt, valid_nxt;
    logic         slot_free, done_seen;

    assign slot_free = !if_to_dec_valid || dec_to_if_ready;
    // Completion pulses only mean something while a request is outstanding.
    assign done_seen = if_to_mc_req && mc_to_if_done;

    assign if_to_ic_inst_addr  = (state == LOOKUP) ? pc : miss_addr;
    assign if_to_ic_inst       = mc_to_if_inst;
    assign if_to_ic_inst_valid = rdy_in && (state != LOOKUP) && done_seen;

    always_comb begin
        // NOTE: every next-value gets a default first so no path leaves it unassigned (no latch).
        state_nxt     = state;
        pc_nxt        = pc;
        miss_addr_nxt = miss_addr;
        mc_addr_nxt   = if_to_mc_addr;
        req_nxt       = if_to_mc_req;
        valid_nxt     = if_to_dec_valid;
        dec_inst_nxt  = if_to_dec_inst;
        dec_pc_nxt    = if_to_dec_pc;

        if (if_to_dec_valid && dec_to_if_ready) begin
            valid_nxt = 1'b0;
        end

        case (state)
            LOOKUP: begin
                if (!rob_to_if_jump && slot_free) begin
                    if (ic_to_if_hit) begin
                        valid_nxt    = 1'b1;
                        dec_inst_nxt = ic_to_if_hit_inst;
                        dec_pc_nxt   = pc;
                        pc_nxt       = pc + PC_STEP;
                    end else begin
                        req_nxt       = 1'b1;
                        mc_addr_nxt   = pc;
                        miss_addr_nxt = pc;
                        state_nxt     = MISS;
                    end
                end
            end
            MISS: begin
                if (done_seen) begin
                    req_nxt   = 1'b0;
                    state_nxt = LOOKUP;
                    if (!rob_to_if_jump) begin
                        valid_nxt    = 1'b1;
                        dec_inst_nxt = mc_to_if_inst;
                        dec_pc_nxt   = miss_addr;
                        pc_nxt       = pc + PC_STEP;
                    end
                end else if (rob_to_if_jump) begin
                    // The request cannot be cancelled; wait it out without delivering.
                    state_nxt = DISCARD;
                end
            end
            DISCARD: begin
                if (done_seen) begin
                    req_nxt   = 1'b0;
                    state_nxt = LOOKUP;
                end
            end
            default: state_nxt = LOOKUP;
        endcase

        // A redirect overrides slot and PC updates in every state.
        if (rob_to_if_jump) begin
            valid_nxt = 1'b0;
            pc_nxt    = rob_to_if_jump_addr;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state           <= LOOKUP;
            pc              <= RESET_PC;
            miss_addr       <= '0;
            if_to_mc_req    <= 1'b0;
            if_to_mc_addr   <= '0;
            if_to_dec_valid <= 1'b0;
            if_to_dec_inst  <= '0;
            if_to_dec_pc    <= '0;
        end else if (rdy_in) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state           <= state_nxt;
            pc              <= pc_nxt;
            miss_addr       <= miss_addr_nxt;
            if_to_mc_req    <= req_nxt;
            if_to_mc_addr   <= mc_addr_nxt;
            if_to_dec_valid <= valid_nxt;
            if_to_dec_inst  <= dec_inst_nxt;
            if_to_dec_pc    <= dec_pc_nxt;
        end
    end

endmodule

// File: tb/tb_instruction_fetcher.sv
// Self-checking bench for instruction_fetcher: directed scenarios followed by a
// randomized run, scored against an in-order PC stream model with cache/memory models.
module tb_instruction_fetcher;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] if_to_ic_inst_addr;
    logic        ic_to_if_hit;
    logic [31:0] ic_to_if_hit_inst;
    logic [31:0] if_to_ic_inst;
    logic        if_to_ic_inst_valid;
    logic        if_to_mc_req;
    logic [31:0] if_to_mc_addr;
    logic        mc_to_if_done;
    logic [31:0] mc_to_if_inst;
    logic        if_to_dec_valid;
    logic [31:0] if_to_dec_inst;
    logic [31:0] if_to_dec_pc;
    logic        dec_to_if_ready;
    logic        rob_to_if_jump;
    logic [31:0] rob_to_if_jump_addr;

    always #5 clk_in = ~clk_in;

    instruction_fetcher dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .rdy_in              (rdy_in),
        .if_to_ic_inst_addr  (if_to_ic_inst_addr),
        .ic_to_if_hit        (ic_to_if_hit),
        .ic_to_if_hit_inst   (ic_to_if_hit_inst),
        .if_to_ic_inst       (if_to_ic_inst),
        .if_to_ic_inst_valid (if_to_ic_inst_valid),
        .if_to_mc_req        (if_to_mc_req),
        .if_to_mc_addr       (if_to_mc_addr),
        .mc_to_if_done       (mc_to_if_done),
        .mc_to_if_inst       (mc_to_if_inst),
        .if_to_dec_valid     (if_to_dec_valid),
        .if_to_dec_inst      (if_to_dec_inst),
        .if_to_dec_pc        (if_to_dec_pc),
        .dec_to_if_ready     (dec_to_if_ready),
        .rob_to_if_jump      (rob_to_if_jump),
        .rob_to_if_jump_addr (rob_to_if_jump_addr)
    );

    // Memory image: what any address holds, whether served by the cache or memory.
    function automatic logic [31:0] data_of(input logic [31:0] a, input int mode);
        if (mode == 2)                      return {a[15:0] ^ 16'h5a5a, ~a[31:16]};
        else if (mode == 1 && a == 32'h100) return 32'hDEAD_BEEF;
        else                                return 32'h0000_0013;
    endfunction

    function automatic logic hit_of(input logic [31:0] a, input int mode);
        if (mode == 0)      return 1'b1;
        else if (mode == 1) return a != 32'h100;
        else                return a[4:2] != a[7:5];
    endfunction

    int hit_mode;

    always_comb begin
        ic_to_if_hit      = hit_of(if_to_ic_inst_addr, hit_mode);
        ic_to_if_hit_inst = data_of(if_to_ic_inst_addr, hit_mode);
    end

    int          vectors;
    int          miscompares;
    int          deliveries;
    int          fill_cnt;
    int          mc_cnt;
    int          mc_lat;
    int          fill0;
    bit          mc_busy;
    logic [31:0] mc_addr;
    logic [31:0] last_fill;
    logic [31:0] exp_pc;
    logic [31:0] snap_pc;
    logic [31:0] snap_ia;
    logic        snap_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive the memory controller, score at the falling edge, then
    // return 1 time unit after the next rising edge.
    task automatic cycle();
        if (mc_busy && mc_cnt == 0 && rdy_in && rst_in) begin
            mc_to_if_done = 1'b1;
            mc_to_if_inst = data_of(mc_addr, hit_mode);
        end else begin
            mc_to_if_done = 1'b0;
            mc_to_if_inst = $urandom;
        end
        @(negedge clk_in);
        if (rst_in) begin
            check("fill_strobe", 32'(if_to_ic_inst_valid), 32'(mc_to_if_done));
            if (if_to_ic_inst_valid) begin
                check("fill_addr", if_to_ic_inst_addr, mc_addr);
                check("fill_data", if_to_ic_inst, data_of(mc_addr, hit_mode));
                fill_cnt++;
                last_fill = mc_addr;
            end
            if (mc_busy) begin
                check("mc_req_held", 32'(if_to_mc_req), 32'd1);
                check("mc_addr_stable", if_to_mc_addr, mc_addr);
            end
            if (rdy_in && if_to_dec_valid && dec_to_if_ready && !rob_to_if_jump) begin
                check("deliver_pc", if_to_dec_pc, exp_pc);
                check("deliver_inst", if_to_dec_inst, data_of(exp_pc, hit_mode));
                exp_pc = exp_pc + 32'd4;
                deliveries++;
            end
            if (rdy_in && rob_to_if_jump) exp_pc = rob_to_if_jump_addr;
            if (mc_to_if_done) begin
                mc_busy = 1'b0;
            end else if (mc_busy) begin
                if (rdy_in && mc_cnt > 0) mc_cnt--;
            end else if (if_to_mc_req) begin
                mc_busy = 1'b1;
                mc_addr = if_to_mc_addr;
                mc_cnt  = mc_lat;
            end
        end else begin
            mc_busy = 1'b0;
        end
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        vectors = 0; miscompares = 0; deliveries = 0; fill_cnt = 0;
        mc_busy = 1'b0; mc_cnt = 0; mc_lat = 5; mc_addr = '0; last_fill = '0;
        hit_mode = 0; exp_pc = 32'h0;
        rst_in = 1'b0; rdy_in = 1'b1; dec_to_if_ready = 1'b0;
        rob_to_if_jump = 1'b0; rob_to_if_jump_addr = '0;
        mc_to_if_done = 1'b0; mc_to_if_inst = '0;

        // Reset: everything quiet, lookup address at the reset PC.
        cycle();
        cycle();
        check("rst_dec_valid", 32'(if_to_dec_valid), 32'd0);
        check("rst_dec_inst", if_to_dec_inst, 32'd0);
        check("rst_dec_pc", if_to_dec_pc, 32'd0);
        check("rst_mc_req", 32'(if_to_mc_req), 32'd0);
        check("rst_mc_addr", if_to_mc_addr, 32'd0);
        check("rst_fill_valid", 32'(if_to_ic_inst_valid), 32'd0);
        check("rst_ic_addr", if_to_ic_inst_addr, 32'd0);

        // Streaming hits, one per cycle.
        rst_in = 1'b1;
        dec_to_if_ready = 1'b1;
        cycle();
        check("hit_first_valid", 32'(if_to_dec_valid), 32'd1);
        check("hit_first_pc", if_to_dec_pc, 32'h0);
        cycle();
        check("hit_second_pc", if_to_dec_pc, 32'h4);
        cycle();
        check("hit_third_pc", if_to_dec_pc, 32'h8);

        // Backpressure at pc 8.
        dec_to_if_ready = 1'b0;
        repeat (3) begin
            cycle();
            check("bp_valid", 32'(if_to_dec_valid), 32'd1);
            check("bp_pc", if_to_dec_pc, 32'h8);
            check("bp_inst", if_to_dec_inst, 32'h13);
            check("bp_lookup_pc", if_to_ic_inst_addr, 32'hC);
            check("bp_no_req", 32'(if_to_mc_req), 32'd0);
        end

        // Miss at 0x100, five-cycle memory latency.
        dec_to_if_ready = 1'b1;
        hit_mode = 1;
        mc_lat = 5;
        rob_to_if_jump = 1'b1; rob_to_if_jump_addr = 32'h100;
        cycle();
        rob_to_if_jump = 1'b0;
        check("jmp_drop_valid", 32'(if_to_dec_valid), 32'd0);
        check("jmp_lookup_pc", if_to_ic_inst_addr, 32'h100);
        cycle();
        check("miss_req", 32'(if_to_mc_req), 32'd1);
        check("miss_req_addr", if_to_mc_addr, 32'h100);
        for (int i = 0; i < 20 && !if_to_dec_valid; i++) cycle();
        check("miss_slot_valid", 32'(if_to_dec_valid), 32'd1);
        check("miss_slot_pc", if_to_dec_pc, 32'h100);
        check("miss_slot_inst", if_to_dec_inst, 32'hDEAD_BEEF);
        check("miss_next_lookup", if_to_ic_inst_addr, 32'h104);
        check("miss_fill_count", 32'(fill_cnt), 32'd1);
        check("miss_req_dropped", 32'(if_to_mc_req), 32'd0);

        // Redirect two cycles after the request: fill happens, nothing delivered.
        fill0 = fill_cnt;
        mc_lat = 6;
        rob_to_if_jump = 1'b1; rob_to_if_jump_addr = 32'h100;
        cycle();
        rob_to_if_jump = 1'b0;
        cycle();
        check("disc_req", 32'(if_to_mc_req), 32'd1);
        cycle();
        cycle();
        rob_to_if_jump = 1'b1; rob_to_if_jump_addr = 32'h200;
        cycle();
        rob_to_if_jump = 1'b0;
        for (int i = 0; i < 30 && !if_to_dec_valid; i++) cycle();
        check("disc_first_pc", if_to_dec_pc, 32'h200);
        check("disc_fill_count", 32'(fill_cnt), 32'(fill0 + 1));
        check("disc_fill_addr", last_fill, 32'h100);

        // Redirect in the same cycle as done.
        fill0 = fill_cnt;
        mc_lat = 3;
        rob_to_if_jump = 1'b1; rob_to_if_jump_addr = 32'h100;
        cycle();
        rob_to_if_jump = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mc_busy && mc_cnt == 0) begin
                rob_to_if_jump = 1'b1; rob_to_if_jump_addr = 32'h300;
                cycle();
                rob_to_if_jump = 1'b0;
                break;
            end
            cycle();
        end
        check("jd_no_slot", 32'(if_to_dec_valid), 32'd0);
        check("jd_fill_count", 32'(fill_cnt), 32'(fill0 + 1));
        check("jd_lookup_pc", if_to_ic_inst_addr, 32'h300);
        cycle();
        check("jd_first_pc", if_to_dec_pc, 32'h300);

        // Redirect with a valid slot being accepted: slot is dropped anyway.
        check("jr_pre_valid", 32'(if_to_dec_valid), 32'd1);
        hit_mode = 0;
        rob_to_if_jump = 1'b1; rob_to_if_jump_addr = 32'h400;
        cycle();
        rob_to_if_jump = 1'b0;
        check("jr_dropped", 32'(if_to_dec_valid), 32'd0);
        check("jr_lookup_pc", if_to_ic_inst_addr, 32'h400);
        cycle();
        check("jr_first_pc", if_to_dec_pc, 32'h400);

        // Freeze mid-stream.
        cycle();
        snap_pc = if_to_dec_pc; snap_valid = if_to_dec_valid; snap_ia = if_to_ic_inst_addr;
        rdy_in = 1'b0;
        repeat (4) begin
            cycle();
            check("frz_pc", if_to_dec_pc, snap_pc);
            check("frz_valid", 32'(if_to_dec_valid), 32'(snap_valid));
            check("frz_lookup_pc", if_to_ic_inst_addr, snap_ia);
            check("frz_fill_valid", 32'(if_to_ic_inst_valid), 32'd0);
        end
        rdy_in = 1'b1;
        cycle();

        // PC wrap-around.
        rob_to_if_jump = 1'b1; rob_to_if_jump_addr = 32'hFFFF_FFFC;
        cycle();
        rob_to_if_jump = 1'b0;
        cycle();
        check("wrap_pc", if_to_dec_pc, 32'hFFFF_FFFC);
        check("wrap_next_lookup", if_to_ic_inst_addr, 32'h0);
        cycle();
        check("wrap_after_pc", if_to_dec_pc, 32'h0);

        // Randomized traffic against the stream model.
        hit_mode = 2;
        rob_to_if_jump = 1'b1; rob_to_if_jump_addr = 32'h40;
        cycle();
        fill0 = deliveries;
        for (int n = 0; n < 3000; n++) begin
            rdy_in          = ($urandom_range(0, 9) != 0);
            dec_to_if_ready = ($urandom_range(0, 3) != 0);
            rob_to_if_jump  = ($urandom_range(0, 31) == 0);
            rob_to_if_jump_addr = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0
                                                               : {18'd0, 12'($urandom_range(0, 4095)), 2'b00};
            mc_lat = $urandom_range(0, 6);
            cycle();
        end
        check("rand_progress", 32'(deliveries - fill0 > 500), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instruction_fetcher.md
# instruction_fetcher

- Front-end fetch stage of the out-of-order RISC-V core.
- Owns the PC and probes the instruction cache combinationally each cycle.
- On a miss, requests the word from the memory controller and writes the returned word into the cache.
- Delivers instructions with their PCs to the decoder through a one-entry valid/ready output slot, and accepts PC redirects from the ROB on mispredicts.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded at reset.
- clk_in  input  1  clock; all state updates on rising edge.
- rst_in  input  1  reset, asynchronous, active-low.
- rdy_in  input  1  global ready; low freezes all registers.
- if_to_ic_inst_addr  output  32  lookup/fill address: PC in LOOKUP, miss_addr otherwise.
- ic_to_if_hit  input  1  cache hit for if_to_ic_inst_addr (same cycle).
- ic_to_if_hit_inst  input  32  hit instruction.
- if_to_ic_inst  output  32  fill data (= mc_to_if_inst).
- if_to_ic_inst_valid  output  1  fill strobe, one cycle.
- if_to_mc_req  output  1  miss request, held until done.
- if_to_mc_addr  output  32  miss address (registered).
- mc_to_if_done  input  1  one-cycle completion pulse.
- mc_to_if_inst  input  32  returned word, valid with done.
- if_to_dec_valid  output  1  output slot holds an instruction.
- if_to_dec_inst  output  32  instruction in slot.
- if_to_dec_pc  output  32  its PC.
- dec_to_if_ready  input  1  decoder accepts slot this cycle.
- rob_to_if_jump  input  1  redirect/flush.
- rob_to_if_jump_addr  input  32  redirect target.

## Operation
- States: LOOKUP, MISS, DISCARD.
- Slot free: `free = !if_to_dec_valid || dec_to_if_ready`.
- **LOOKUP**
  - free && hit: load slot {inst, pc}, valid<=1, pc<=pc+4.
  - free && !hit: if_to_mc_req<=1, if_to_mc_addr<=pc, miss_addr<=pc, go to MISS.
  - !free: hold.
- **MISS**
  - The slot is guaranteed empty here.
  - On done: if_to_ic_inst_valid=1 combinationally with addr=miss_addr; load slot {mc_to_if_inst, miss_addr}, valid<=1; pc<=pc+4; req<=0; go to LOOKUP.
- **DISCARD**
  - Waits out an uncancellable request.
  - On done: perform the cache fill but do not load the slot; req<=0; go to LOOKUP.
- **Redirect** (rob_to_if_jump) has the highest priority in every state:
  - Effects: valid<=0 (slot dropped, even if dec_to_if_ready); pc<=target.
  - LOOKUP: stays in LOOKUP, with no request and no slot load this cycle.
  - MISS without done: go to DISCARD.
  - MISS with done: fill is performed, slot not loaded, go to LOOKUP.
  - DISCARD: update pc only.
- rdy_in low: no register changes; if_to_ic_inst_valid forced 0.
- PC arithmetic: 32-bit wrap-around; 32'hFFFF_FFFC+4 = 0.

## Timing
- Reset values: pc=RESET_PC, state=LOOKUP, if_to_dec_valid=0, if_to_mc_req=0, if_to_mc_addr=0, miss_addr=0, if_to_dec_inst=0, if_to_dec_pc=0.
- Combinational outputs at reset: if_to_ic_inst_valid=0, if_to_ic_inst_addr=RESET_PC.
- Hit latency: 1 cycle from PC to if_to_dec_valid.
- Hit throughput: 1 instruction/cycle while dec_to_if_ready stays high.
- Miss: req rises the cycle after the miss is detected; slot valid the cycle after done; the next lookup at pc+4 occurs in that same cycle.
- Handshakes:
  - Slot contents stay stable while valid && !ready.
  - if_to_mc_addr stays stable while req is high.
  - Done is ignored when req is low.
- Asynchronous reset mid-miss abandons the request immediately; the memory controller is reset by the same signal.

## Structure
- Shared package/header:
  - Existing `ADDR_TYPE`/`INST_TYPE` width macros.
  - Fetcher state encodings.
  - RESET_PC default.
- Single flat module; no sub-module.

## Test plan
- **Reset:** RESET_PC=0, cache always hits with 32'h0000_0013 → slot shows pc 0,4,8,… one per cycle with ready=1; all outputs 0 during reset.
- **Backpressure:** ready=0 for 3 cycles at pc 8 → slot holds {0x13, 8}, PC stays 12, no request issued.
- **Miss:** pc 0x100 misses, done after 5 cycles with 32'hDEAD_BEEF → req high with addr 0x100 until done; fill strobe addr 0x100 in the done cycle; slot {DEADBEEF, 0x100} next cycle; next lookup at 0x104.
- **Redirect during miss:** jump to 0x200 two cycles after req → DISCARD; on done, fill 0x100 but slot stays empty; first delivered PC is 0x200.
- **Simultaneous events:**
  - jump with done in MISS → fill occurs, no delivery.
  - jump with ready and a valid slot → slot dropped, next PC = target.
- **Freeze and wrap:** rdy_in low for 4 cycles mid-stream → no state change. pc 32'hFFFF_FFFC hit → next PC is 0.
